// File: rtl/led_scan_pwm_pkg.sv
// Shared types and constants for the LED-cube plane scanner.
package led_scan_pwm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WAIT  = 3'd2,
        S_DATA  = 3'd3,
        S_SCLK  = 3'd4,
        S_LATCH = 3'd5,
        S_HOLD  = 3'd6
    } state_t;

    localparam int ADDR_W = 7;
    localparam int LANES  = 8;

    // Highest PWM threshold; a full-scale byte stays on for every step.
    function automatic int step_max(input int bits);
        return (1 << bits) - 2;
    endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// Eight-lane brightness-versus-threshold comparator feeding the serial lanes.
module led_pwm_cmp
    import led_scan_pwm_pkg::*;
(
    input  logic [63:0]      data_i,
    input  logic [7:0]       step_i,
    output logic [LANES-1:0] mask_o
);

    always_comb begin
        mask_o = '0;
        for (int n = 0; n < LANES; n++) begin
            mask_o[n] = (data_i[8*n +: 8] > step_i);
        end
    end

endmodule

// File: rtl/led_scan_pwm.sv
// Scans the frame-buffer read port plane by plane, emits PWM bits on eight
// serial driver lanes, then latches and lights the selected plane.
module led_scan_pwm
    import led_scan_pwm_pkg::*;
#(
    parameter int PLANES   = 5,
    parameter int WORDS    = 16,
    parameter int PWM_BITS = 8,
    parameter int HOLD     = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [63:0]       ram_data_i,
    output logic [LANES-1:0]  led_sdata_o,
    output logic              led_sclk_o,
    output logic              led_latch_o,
    output logic              led_oe_n_o,
    output logic [PLANES-1:0] led_plane_o,
    output logic              frame_o
);

    localparam int STEP_MAX = step_max(PWM_BITS);
    localparam int PL_W     = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int WORD_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int HOLD_W   = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t              state_q, state_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [PWM_BITS-1:0] step_q, step_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LANES-1:0]    sdata_q, sdata_d;
    logic                sclk_q, sclk_d;
    logic                latch_q, latch_d;
    logic                oe_n_q, oe_n_d;
    logic [PLANES-1:0]   plane_sel_q, plane_sel_d;
    logic                frame_q, frame_d;
    logic [LANES-1:0]    lane_mask;

    led_pwm_cmp u_cmp (
        .data_i (ram_data_i),
        .step_i (step_q),
        .mask_o (lane_mask)
    );

    // Strobe-type outputs are decoded from the next state so each one is
    // registered and lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        plane_d     = plane_q;
        step_d      = step_q;
        word_d      = word_q;
        hold_d      = hold_q;
        addr_d      = addr_q;
        sdata_d     = sdata_q;
        plane_sel_d = plane_sel_q;
        sclk_d      = 1'b0;
        latch_d     = 1'b0;
        oe_n_d      = 1'b1;
        frame_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en_i) state_d = S_ADDR;
            end
            S_ADDR: begin
                addr_d  = ADDR_W'(int'(plane_q) * WORDS + int'(word_q));
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                sdata_d = lane_mask;
                sclk_d  = 1'b1;
                state_d = S_SCLK;
            end
            S_SCLK: begin
                if (word_q == WORD_W'(WORDS - 1)) begin
                    word_d  = '0;
                    latch_d = 1'b1;
                    state_d = S_LATCH;
                end else begin
                    word_d  = word_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_LATCH: begin
                plane_sel_d = PLANES'(1) << plane_q;
                hold_d      = '0;
                oe_n_d      = 1'b0;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(HOLD - 1)) begin
                    if (step_q == PWM_BITS'(STEP_MAX)) begin
                        step_d = '0;
                        if (plane_q == PL_W'(PLANES - 1)) begin
                            plane_d = '0;
                            frame_d = 1'b1;
                        end else begin
                            plane_d = plane_q + 1'b1;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                    if (en_i) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d     = S_IDLE;
                        step_d      = '0;
                        plane_d     = '0;
                        word_d      = '0;
                        plane_sel_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                    oe_n_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            plane_q     <= '0;
            step_q      <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            sclk_q      <= 1'b0;
            latch_q     <= 1'b0;
            oe_n_q      <= 1'b1;
            plane_sel_q <= '0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            plane_q     <= plane_d;
            step_q      <= step_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            sclk_q      <= sclk_d;
            latch_q     <= latch_d;
            oe_n_q      <= oe_n_d;
            plane_sel_q <= plane_sel_d;
            frame_q     <= frame_d;
        end
    end

    assign ram_addr_o  = addr_q;
    assign led_sdata_o = sdata_q;
    assign led_sclk_o  = sclk_q;
    assign led_latch_o = latch_q;
    assign led_oe_n_o  = oe_n_q;
    assign led_plane_o = plane_sel_q;
    assign frame_o     = frame_q;

endmodule

// File: tb/tb_led_scan_pwm.sv
// Directed bench: a one-word scanner for timing/PWM duty and a three-plane,
// four-word scanner for addressing, frame pulse and enable handling.
module tb_led_scan_pwm;

    logic clk;
    int   checks;
    int   errors;
    bit   abort;

    // Instance A: PLANES=1, WORDS=1, HOLD=4 (row = 9 cycles)
    logic        rst_a, en_a;
    logic [6:0]  addr_a;
    logic [63:0] ram_a, word_a;
    logic [7:0]  sdata_a;
    logic        sclk_a, latch_a, oe_n_a, frame_a;
    logic [0:0]  plane_a;
    int          frame_cnt_a;

    // Instance B: PLANES=3, WORDS=4, HOLD=2 (row = 19 cycles)
    logic        rst_b, en_b;
    logic [6:0]  addr_b;
    logic [63:0] ram_b;
    logic [63:0] mem_b [0:15];
    logic [7:0]  sdata_b;
    logic        sclk_b, latch_b, oe_n_b, frame_b;
    logic [2:0]  plane_b;
    int          frame_cnt_b;

    led_scan_pwm #(.PLANES(1), .WORDS(1), .PWM_BITS(8), .HOLD(4)) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_a),
        .en_i        (en_a),
        .ram_addr_o  (addr_a),
        .ram_data_i  (ram_a),
        .led_sdata_o (sdata_a),
        .led_sclk_o  (sclk_a),
        .led_latch_o (latch_a),
        .led_oe_n_o  (oe_n_a),
        .led_plane_o (plane_a),
        .frame_o     (frame_a)
    );

    led_scan_pwm #(.PLANES(3), .WORDS(4), .PWM_BITS(8), .HOLD(2)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_b),
        .en_i        (en_b),
        .ram_addr_o  (addr_b),
        .ram_data_i  (ram_b),
        .led_sdata_o (sdata_b),
        .led_sclk_o  (sclk_b),
        .led_latch_o (latch_b),
        .led_oe_n_o  (oe_n_b),
        .led_plane_o (plane_b),
        .frame_o     (frame_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM read ports
    always_ff @(posedge clk) ram_a <= (addr_a == 7'd0) ? word_a : 64'd0;
    always_ff @(posedge clk) ram_b <= (addr_b < 7'd12) ? mem_b[addr_b[3:0]] : 64'd0;

    always begin
        @(posedge clk);
        #2;
        if (frame_a) frame_cnt_a++;
    end

    // Driver-protocol monitor on instance B
    logic       prev_sclk_b;
    logic [7:0] prev_sdata_b;
    int         sclk_cnt_b;
    always begin
        @(posedge clk);
        #2;
        if (!rst_b) begin
            prev_sclk_b = 1'b0;
            sclk_cnt_b  = 0;
        end else begin
            checks++;
            if (sclk_b && latch_b) begin
                errors++;
                $display("FAIL sclk_latch_overlap t=%0t sclk=%b latch=%b required not both high", $time, sclk_b, latch_b);
            end
            if (prev_sclk_b) begin
                checks++;
                if (sdata_b !== prev_sdata_b) begin
                    errors++;
                    $display("FAIL sdata_stable t=%0t got %b required %b", $time, sdata_b, prev_sdata_b);
                end
            end
            if (sclk_b) sclk_cnt_b++;
            if (latch_b) begin
                checks++;
                if (sclk_cnt_b !== 4) begin
                    errors++;
                    $display("FAIL sclk_per_latch t=%0t got %0d required 4", $time, sclk_cnt_b);
                end
                sclk_cnt_b = 0;
            end
            if (frame_b) frame_cnt_b++;
            prev_sclk_b  = sclk_b;
            prev_sdata_b = sdata_b;
        end
    end

    // Bounded wait: 0 sclk_a, 1 latch_a, 2 sclk_b, 3 latch_b
    task automatic wait_ev(input int which, input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            n = i;
            case (which)
                0: ok = sclk_a;
                1: ok = latch_a;
                2: ok = sclk_b;
                default: ok = latch_b;
            endcase
            if (ok) break;
        end
        if (!ok) begin
            checks++;
            errors++;
            abort = 1'b1;
            $display("FAIL wait_timeout event=%0d got no event required one within %0d cycles", which, limit);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({addr_a, sdata_a, sclk_a, latch_a, oe_n_a, plane_a, frame_a} !== {7'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a got addr=%0d sdata=%b sclk=%b latch=%b oe_n=%b plane=%b frame=%b required 0,0,0,0,1,0,0",
                     addr_a, sdata_a, sclk_a, latch_a, oe_n_a, plane_a, frame_a);
        end
        checks++;
        if ({addr_b, sdata_b, sclk_b, latch_b, oe_n_b, plane_b, frame_b} !== {7'd0, 8'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b got addr=%0d sdata=%b sclk=%b latch=%b oe_n=%b plane=%b frame=%b required 0,0,0,0,1,0,0",
                     addr_b, sdata_b, sclk_b, latch_b, oe_n_b, plane_b, frame_b);
        end
    endtask

    task automatic test_single_word;
        int n;
        bit ok;
        int hold_cnt;
        logic [0:0] plane_seen;
        word_a = 64'hFF00_8001_0000_00FF;
        en_a   = 1'b1;
        rst_a  = 1'b1;
        wait_ev(0, 50, n, ok);
        if (abort) return;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL first_sclk_latency got %0d required 4", n); end
        checks++;
        if (sdata_a !== 8'b1011_0001) begin errors++; $display("FAIL sdata_step0 got %b required 10110001", sdata_a); end
        checks++;
        if (addr_a !== 7'd0) begin errors++; $display("FAIL addr_single got %0d required 0", addr_a); end
        @(posedge clk);
        #1;
        checks++;
        if ({latch_a, sclk_a, oe_n_a} !== 3'b101) begin
            errors++;
            $display("FAIL latch_cycle got latch=%b sclk=%b oe_n=%b required 1,0,1", latch_a, sclk_a, oe_n_a);
        end
        hold_cnt   = 0;
        plane_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (oe_n_a === 1'b0) begin
                hold_cnt++;
                plane_seen = plane_a;
            end else break;
        end
        checks++;
        if (hold_cnt !== 4) begin errors++; $display("FAIL hold_length got %0d required 4", hold_cnt); end
        checks++;
        if (plane_seen !== 1'b1) begin errors++; $display("FAIL plane_during_hold got %b required 1", plane_seen); end
        wait_ev(0, 50, n, ok);
        if (abort) return;
        checks++;
        if (n !== 3) begin errors++; $display("FAIL next_row_latency got %0d required 3", n); end
        checks++;
        if (sdata_a !== 8'b1010_0001) begin errors++; $display("FAIL sdata_step1 got %b required 10100001", sdata_a); end
    endtask

    task automatic test_pwm_duty;
        int n;
        bit ok;
        int cnt [0:7];
        rst_a = 1'b0;
        word_a = 64'h0000_00FE_0180_00FF;
        repeat (2) @(posedge clk);
        #1;
        frame_cnt_a = 0;
        for (int l = 0; l < 8; l++) cnt[l] = 0;
        rst_a = 1'b1;
        for (int r = 0; r < 255; r++) begin
            wait_ev(0, 50, n, ok);
            if (abort) return;
            for (int l = 0; l < 8; l++) cnt[l] += int'(sdata_a[l]);
        end
        checks++;
        if (frame_cnt_a !== 0) begin errors++; $display("FAIL frame_early_a got %0d required 0", frame_cnt_a); end
        checks++;
        if (cnt[0] !== 255) begin errors++; $display("FAIL duty_ff got %0d required 255", cnt[0]); end
        checks++;
        if (cnt[1] !== 0) begin errors++; $display("FAIL duty_00 got %0d required 0", cnt[1]); end
        checks++;
        if (cnt[2] !== 128) begin errors++; $display("FAIL duty_80 got %0d required 128", cnt[2]); end
        checks++;
        if (cnt[3] !== 1) begin errors++; $display("FAIL duty_01 got %0d required 1", cnt[3]); end
        checks++;
        if (cnt[4] !== 254) begin errors++; $display("FAIL duty_fe got %0d required 254", cnt[4]); end
        wait_ev(0, 50, n, ok);
        if (abort) return;
        checks++;
        if (frame_cnt_a !== 1) begin errors++; $display("FAIL frame_count_a got %0d required 1", frame_cnt_a); end
        checks++;
        if (sdata_a !== 8'b0001_1101) begin errors++; $display("FAIL step_wrap got %b required 00011101", sdata_a); end
    endtask

    task automatic test_reset_mid_hold;
        int n;
        bit ok;
        bit found;
        bit idle_bad;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (oe_n_a === 1'b0) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_hold got none required oe_n low within 50 cycles"); return; end
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({addr_a, sdata_a, sclk_a, latch_a, oe_n_a, plane_a, frame_a} !== {7'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_hold got addr=%0d sdata=%b sclk=%b latch=%b oe_n=%b plane=%b frame=%b required 0,0,0,0,1,0,0",
                     addr_a, sdata_a, sclk_a, latch_a, oe_n_a, plane_a, frame_a);
        end
        repeat (2) @(posedge clk);
        #1;
        en_a  = 1'b0;
        rst_a = 1'b1;
        idle_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (sclk_a !== 1'b0 || oe_n_a !== 1'b1 || addr_a !== 7'd0) idle_bad = 1'b1;
        end
        checks++;
        if (idle_bad) begin errors++; $display("FAIL idle_after_reset got activity required idle outputs"); end
        en_a = 1'b1;
        wait_ev(0, 50, n, ok);
        if (abort) return;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL restart_latency got %0d required 4", n); end
        checks++;
        if (sdata_a !== 8'b0001_1101) begin errors++; $display("FAIL restart_step0 got %b required 00011101", sdata_a); end
    endtask

    task automatic test_address_seq;
        int n;
        bit ok;
        int plane;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frame_cnt_b = 0;
        en_b  = 1'b1;
        rst_b = 1'b1;
        for (int r = 0; r < 765; r++) begin
            plane = r / 255;
            if (r == 764) begin
                checks++;
                if (frame_cnt_b !== 0) begin errors++; $display("FAIL frame_early_b got %0d required 0", frame_cnt_b); end
            end
            for (int w = 0; w < 4; w++) begin
                wait_ev(2, 50, n, ok);
                if (abort) return;
                checks++;
                if (addr_b !== 7'(plane * 4 + w)) begin
                    errors++;
                    $display("FAIL addr_seq row=%0d word=%0d got %0d required %0d", r, w, addr_b, plane * 4 + w);
                end
            end
            wait_ev(3, 10, n, ok);
            if (abort) return;
            @(posedge clk);
            #1;
            checks++;
            if (plane_b !== 3'(1 << plane)) begin
                errors++;
                $display("FAIL plane_sel row=%0d got %b required %b", r, plane_b, 3'(1 << plane));
            end
        end
        wait_ev(2, 50, n, ok);
        if (abort) return;
        checks++;
        if (addr_b !== 7'd0) begin errors++; $display("FAIL addr_after_frame got %0d required 0", addr_b); end
        checks++;
        if (frame_cnt_b !== 1) begin errors++; $display("FAIL frame_count_b got %0d required 1", frame_cnt_b); end
    endtask

    task automatic test_enable_drop;
        int n;
        bit ok;
        int hold_cnt;
        bit idle_bad;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        en_b  = 1'b1;
        rst_b = 1'b1;
        wait_ev(2, 50, n, ok);
        if (abort) return;
        wait_ev(2, 50, n, ok);
        if (abort) return;
        en_b = 1'b0;
        for (int w = 2; w < 4; w++) begin
            wait_ev(2, 50, n, ok);
            if (abort) return;
            checks++;
            if (addr_b !== 7'(w)) begin errors++; $display("FAIL drop_addr word=%0d got %0d required %0d", w, addr_b, w); end
        end
        wait_ev(3, 10, n, ok);
        if (abort) return;
        hold_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (oe_n_b === 1'b0) hold_cnt++;
            else break;
        end
        checks++;
        if (hold_cnt !== 2) begin errors++; $display("FAIL drop_hold got %0d required 2", hold_cnt); end
        checks++;
        if ({oe_n_b, plane_b} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL drop_idle got oe_n=%b plane=%b required 1,000", oe_n_b, plane_b);
        end
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (sclk_b !== 1'b0 || latch_b !== 1'b0 || oe_n_b !== 1'b1 || addr_b !== 7'd3) idle_bad = 1'b1;
        end
        checks++;
        if (idle_bad) begin errors++; $display("FAIL drop_stays_idle got activity required idle with addr held at 3"); end
        en_b = 1'b1;
        wait_ev(2, 50, n, ok);
        if (abort) return;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL reenable_latency got %0d required 4", n); end
        checks++;
        if (addr_b !== 7'd0) begin errors++; $display("FAIL reenable_addr got %0d required 0", addr_b); end
        checks++;
        if (sdata_b !== 8'h01) begin errors++; $display("FAIL reenable_step0 got %b required 00000001", sdata_b); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        abort       = 1'b0;
        frame_cnt_a = 0;
        frame_cnt_b = 0;
        rst_a       = 1'b0;
        rst_b       = 1'b0;
        en_a        = 1'b0;
        en_b        = 1'b0;
        word_a      = 64'd0;
        for (int i = 0; i < 16; i++) mem_b[i] = {48'd0, 8'(i), 8'h01};
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        if (!abort) test_single_word();
        if (!abort) test_pwm_duty();
        if (!abort) test_reset_mid_hold();
        if (!abort) test_address_seq();
        if (!abort) test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
